// File: rtl/operand_fetch.sv
// Operand fetch for the MSP430 datapath: resolves source/destination addressing
// modes against the register file and data memory, writing back autoincrements.
module operand_fetch #(
    parameter int DW          = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [3:0]    src_reg,
    input  logic [1:0]    as_mode,
    input  logic [3:0]    dst_reg,
    input  logic          ad_mode,
    input  logic          bw,
    input  logic [DW-1:0] ext_src,
    input  logic [DW-1:0] ext_dst,
    output logic [3:0]    rf_SA,
    output logic [3:0]    rf_DA,
    output logic [1:0]    rf_As,
    output logic          rf_RW,
    output logic [DW-1:0] rf_Din,
    input  logic [DW-1:0] rf_Sout,
    input  logic [DW-1:0] rf_Dout,
    output logic          mem_rd,
    output logic [DW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [DW-1:0] src_val,
    output logic [DW-1:0] dst_val,
    output logic [DW-1:0] dst_addr,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SRC, SRC_MEM, SRC_INC, DST, DST_MEM, DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    sa_reg, sa_next, da_reg, da_next;
    logic [1:0]    as_reg, as_next;
    logic          ad_reg, ad_next, bw_reg, bw_next, err_reg, err_next;
    logic [DW-1:0] sout_reg, sout_next, maddr_reg, maddr_next;
    logic [DW-1:0] src_val_reg, src_val_next, dst_val_reg, dst_val_next;
    logic [DW-1:0] dst_addr_reg, dst_addr_next;
    logic [CW-1:0] wait_reg, wait_next;
    logic [DW-1:0] inc, ea;

    // Byte reads pick the lane addressed by bit 0; word reads ignore it.
    function automatic logic [DW-1:0] lane(input logic [DW-1:0] w, input logic odd,
                                           input logic byte_op);
        if (!byte_op)
            return w;
        return odd ? {{(DW-8){1'b0}}, w[15:8]} : {{(DW-8){1'b0}}, w[7:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sa_reg       <= '0;
            da_reg       <= '0;
            as_reg       <= '0;
            ad_reg       <= 1'b0;
            bw_reg       <= 1'b0;
            err_reg      <= 1'b0;
            sout_reg     <= '0;
            maddr_reg    <= '0;
            src_val_reg  <= '0;
            dst_val_reg  <= '0;
            dst_addr_reg <= '0;
            wait_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            sa_reg       <= sa_next;
            da_reg       <= da_next;
            as_reg       <= as_next;
            ad_reg       <= ad_next;
            bw_reg       <= bw_next;
            err_reg      <= err_next;
            sout_reg     <= sout_next;
            maddr_reg    <= maddr_next;
            src_val_reg  <= src_val_next;
            dst_val_reg  <= dst_val_next;
            dst_addr_reg <= dst_addr_next;
            wait_reg     <= wait_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sa_next       = sa_reg;
        da_next       = da_reg;
        as_next       = as_reg;
        ad_next       = ad_reg;
        bw_next       = bw_reg;
        err_next      = err_reg;
        sout_next     = sout_reg;
        maddr_next    = maddr_reg;
        src_val_next  = src_val_reg;
        dst_val_next  = dst_val_reg;
        dst_addr_next = dst_addr_reg;
        wait_next     = wait_reg;
        inc           = '0;
        ea            = '0;
        rf_SA         = '0;
        rf_DA         = '0;
        rf_As         = '0;
        rf_RW         = 1'b0;
        rf_Din        = '0;
        mem_rd        = 1'b0;
        mem_addr      = '0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sa_next    = src_reg;
                    as_next    = as_mode;
                    da_next    = dst_reg;
                    ad_next    = ad_mode;
                    bw_next    = bw;
                    err_next   = 1'b0;
                    state_next = SRC;
                end
            end
            SRC: begin
                rf_SA     = sa_reg;
                rf_As     = as_reg;
                sout_next = rf_Sout;
                wait_next = '0;
                if (sa_reg == 4'd3) begin
                    case (as_reg)
                        2'b00:   src_val_next = DW'(0);
                        2'b01:   src_val_next = DW'(1);
                        2'b10:   src_val_next = DW'(2);
                        default: src_val_next = '1;
                    endcase
                    state_next = DST;
                end else if (sa_reg == 4'd2 && as_reg[1]) begin
                    src_val_next = as_reg[0] ? DW'(8) : DW'(4);
                    state_next   = DST;
                end else begin
                    case (as_reg)
                        2'b00: begin
                            src_val_next = lane(rf_Sout, 1'b0, bw_reg);
                            state_next   = DST;
                        end
                        2'b01: begin
                            // R2 indexed is absolute: the SR contents are not a base.
                            maddr_next = (sa_reg == 4'd2) ? ext_src : rf_Sout + ext_src;
                            state_next = SRC_MEM;
                        end
                        default: begin
                            maddr_next = rf_Sout;
                            state_next = SRC_MEM;
                        end
                    endcase
                end
            end
            SRC_MEM: begin
                mem_rd   = 1'b1;
                mem_addr = maddr_reg;
                if (mem_ack) begin
                    src_val_next = lane(mem_rdata, maddr_reg[0], bw_reg);
                    state_next   = (as_reg == 2'b11) ? SRC_INC : DST;
                end else if (wait_reg == WAIT_MAX) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg + CW'(1);
                end
            end
            SRC_INC: begin
                // PC and SP always step by a word, even for byte operations.
                inc        = (bw_reg && sa_reg != 4'd0 && sa_reg != 4'd1) ? DW'(1) : DW'(2);
                rf_RW      = 1'b1;
                rf_DA      = sa_reg;
                rf_Din     = sout_reg + inc;
                state_next = DST;
            end
            DST: begin
                rf_DA     = da_reg;
                wait_next = '0;
                if (!ad_reg) begin
                    dst_val_next  = lane(rf_Dout, 1'b0, bw_reg);
                    dst_addr_next = '0;
                    state_next    = DONE;
                end else begin
                    ea            = (da_reg == 4'd2) ? ext_dst : rf_Dout + ext_dst;
                    dst_addr_next = ea;
                    maddr_next    = ea;
                    state_next    = DST_MEM;
                end
            end
            DST_MEM: begin
                mem_rd   = 1'b1;
                mem_addr = maddr_reg;
                if (mem_ack) begin
                    dst_val_next = lane(mem_rdata, maddr_reg[0], bw_reg);
                    state_next   = DONE;
                end else if (wait_reg == WAIT_MAX) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    wait_next = wait_reg + CW'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign src_val  = src_val_reg;
    assign dst_val  = dst_val_reg;
    assign dst_addr = dst_addr_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign err      = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register-file and memory models plus an
// operand-level reference that predicts values, latency, writebacks and reads.
module tb_operand_fetch;
    localparam int MEM_TIMEOUT = 15;

    logic        clk, rst, start, ad_mode, bw;
    logic [3:0]  src_reg, dst_reg, rf_SA, rf_DA;
    logic [1:0]  as_mode, rf_As;
    logic [15:0] ext_src, ext_dst, rf_Din, rf_Sout, rf_Dout, mem_addr, mem_rdata;
    logic [15:0] src_val, dst_val, dst_addr;
    logic        rf_RW, mem_rd, mem_ack, busy, done, err;

    logic [15:0] rf  [0:15];
    logic [15:0] mem [0:1023];

    typedef struct {
        logic [15:0] src, dst, daddr, src_addr, dst_addr, wb_da, wb_din;
        int          lat, src_mem, dst_mem;
        logic        err, wb;
    } pred_t;

    pred_t pred;
    int    checks, errors, cyc, t_start, ack_wait, rd_cnt, wb_seen, rd_seen, n_op;
    logic  exp_valid, last_err;
    logic [15:0] last_din;
    logic [3:0]  last_da;

    operand_fetch #(.DW(16), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .src_reg(src_reg), .as_mode(as_mode),
        .dst_reg(dst_reg), .ad_mode(ad_mode), .bw(bw), .ext_src(ext_src), .ext_dst(ext_dst),
        .rf_SA(rf_SA), .rf_DA(rf_DA), .rf_As(rf_As), .rf_RW(rf_RW), .rf_Din(rf_Din),
        .rf_Sout(rf_Sout), .rf_Dout(rf_Dout), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .src_val(src_val), .dst_val(dst_val),
        .dst_addr(dst_addr), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_Sout   = rf[rf_SA];
    assign rf_Dout   = rf[rf_DA];
    assign mem_rdata = mem[mem_addr[10:1]];
    assign mem_ack   = mem_rd && (ack_wait >= 0) && (rd_cnt == ack_wait);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd && !mem_ack) rd_cnt <= rd_cnt + 1;
        else rd_cnt <= 0;
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [15:0] fetch(input logic [15:0] a, input logic b);
        logic [15:0] w;
        w = mem[a[10:1]];
        if (!b) return w;
        return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
    endfunction

    // Operand-level reference: what the ALU should receive and how long it takes.
    task automatic predict(input logic [3:0] s, input logic [1:0] a, input logic [3:0] d,
                           input logic ad, input logic b, input logic [15:0] xs,
                           input logic [15:0] xd, input int w);
        logic [15:0] rs, rdv, addr;
        int  mc;
        bit  tout;
        tout = (w < 0) || (w > MEM_TIMEOUT);
        mc   = tout ? MEM_TIMEOUT + 1 : w + 1;
        pred.src = 0; pred.dst = 0; pred.daddr = 0; pred.src_addr = 0; pred.dst_addr = 0;
        pred.wb_da = 0; pred.wb_din = 0; pred.src_mem = 0; pred.dst_mem = 0;
        pred.err = 0; pred.wb = 0;
        pred.lat = 2;
        rs  = rf[s];
        rdv = rf[d];
        if (s == 4'd3) begin
            pred.src = (a == 0) ? 16'h0000 : (a == 1) ? 16'h0001 : (a == 2) ? 16'h0002 : 16'hFFFF;
        end else if (s == 4'd2 && a >= 2) begin
            pred.src = (a == 2) ? 16'h0004 : 16'h0008;
        end else if (a == 0) begin
            pred.src = b ? (rs & 16'h00FF) : rs;
        end else begin
            addr = (a == 1) ? (((s == 4'd2) ? 16'h0000 : rs) + xs) : rs;
            pred.src_addr = addr;
            pred.src_mem  = mc;
            pred.lat     += mc;
            if (tout) begin
                pred.err = 1;
                return;
            end
            pred.src = fetch(addr, b);
            if (a == 3) begin
                pred.wb     = 1;
                pred.wb_da  = {12'h000, s};
                pred.wb_din = rs + ((b && s > 1) ? 16'd1 : 16'd2);
                pred.lat   += 1;
            end
        end
        pred.lat += 1;
        if (!ad) begin
            pred.dst = b ? (rdv & 16'h00FF) : rdv;
        end else begin
            addr          = ((d == 4'd2) ? 16'h0000 : rdv) + xd;
            pred.daddr    = addr;
            pred.dst_addr = addr;
            pred.dst_mem  = mc;
            pred.lat     += mc;
            if (tout) pred.err = 1;
            else pred.dst = fetch(addr, b);
        end
    endtask

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (!rst) begin
            if (rf_RW) begin
                wb_seen++;
                last_da  = rf_DA;
                last_din = rf_Din;
                check("wb_allowed", {31'b0, pred.wb}, 1);
                check("wb_da", {28'b0, rf_DA}, pred.wb_da);
                check("wb_din", rf_Din, pred.wb_din);
            end
            if (mem_rd) begin
                check("mem_addr", mem_addr, (rd_seen < pred.src_mem) ? pred.src_addr : pred.dst_addr);
                rd_seen++;
            end
            if (done) begin
                last_err = err;
                check("done_expected", {31'b0, exp_valid}, 1);
                if (exp_valid) begin
                    check("latency", cyc - t_start, pred.lat);
                    check("err", {31'b0, err}, {31'b0, pred.err});
                    if (!pred.err) begin
                        check("src_val", src_val, pred.src);
                        check("dst_val", dst_val, pred.dst);
                        check("dst_addr", dst_addr, pred.daddr);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [3:0] s, input logic [1:0] a, input logic [3:0] d,
                         input logic ad, input logic b, input logic [15:0] xs,
                         input logic [15:0] xd);
        @(negedge clk);
        src_reg = s; as_mode = a; dst_reg = d; ad_mode = ad; bw = b;
        ext_src = xs; ext_dst = xd; start = 1'b1;
        t_start = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] s, input logic [1:0] a, input logic [3:0] d,
                          input logic ad, input logic b, input logic [15:0] xs,
                          input logic [15:0] xd, input int w);
        bit got;
        predict(s, a, d, ad, b, xs, xd, w);
        ack_wait  = w;
        wb_seen   = 0;
        rd_seen   = 0;
        exp_valid = 1'b1;
        issue(s, a, d, ad, b, xs, xd);
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("done_seen", {31'b0, got}, 1);
        check("wb_count", wb_seen, {31'b0, pred.wb});
        check("rd_cycles", rd_seen, pred.src_mem + pred.dst_mem);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 0);
        check("busy_after", {31'b0, busy}, 0);
        $display("op %0d: src=R%0d As=%0d dst=R%0d Ad=%0d bw=%0d wait=%0d -> src_val=%h dst_val=%h dst_addr=%h err=%0d",
                 n_op, s, a, d, ad, b, w, src_val, dst_val, dst_addr, last_err);
        n_op++;
        if (!got) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; rd_cnt = 0; n_op = 0; ack_wait = 0;
        wb_seen = 0; rd_seen = 0; exp_valid = 1'b0; last_err = 1'b0;
        last_din = 0; last_da = 0; t_start = 0;
        rst = 1'b1; start = 1'b0; src_reg = 0; as_mode = 0; dst_reg = 0;
        ad_mode = 0; bw = 0; ext_src = 0; ext_dst = 0;
        pred.wb = 0; pred.src_mem = 0; pred.src_addr = 0; pred.dst_addr = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'h5500;
        rf[0] = 16'h0000; rf[1] = 16'h0400; rf[2] = 16'h0005; rf[4] = 16'h0200;
        rf[5] = 16'h1234; rf[6] = 16'h00FF; rf[7] = 16'h0300; rf[8] = 16'h0201;
        rf[9] = 16'h0102;
        mem[16'h0200 >> 1] = 16'hABCD;
        mem[16'h0310 >> 1] = 16'h5A3C;
        mem[16'h0400 >> 1] = 16'h1357;
        mem[16'h0110 >> 1] = 16'hBEEF;
        mem[16'h0120 >> 1] = 16'h2468;

        // Reset state, with start asserted to show it is ignored.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_rf_RW", {31'b0, rf_RW}, 0);
        check("rst_mem_rd", {31'b0, mem_rd}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_src_val", src_val, 0);
        check("rst_dst_val", dst_val, 0);
        check("rst_dst_addr", dst_addr, 0);
        check("rst_rf_SA", {28'b0, rf_SA}, 0);
        start = 1'b0;
        rst = 1'b0;

        run_op(4'd5, 2'b00, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 0);
        check("t1_src", src_val, 16'h1234);
        check("t1_dst", dst_val, 16'h00FF);
        run_op(4'd3, 2'b11, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 0);
        check("t2_r3_src", src_val, 16'hFFFF);
        run_op(4'd2, 2'b10, 4'd5, 1'b0, 1'b0, 16'h0, 16'h0, 0);
        check("t2_r2_src", src_val, 16'h0004);
        run_op(4'd4, 2'b11, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 0);
        check("t3_src", src_val, 16'hABCD);
        check("t3_da", {28'b0, last_da}, 4);
        check("t3_din", last_din, 16'h0202);
        run_op(4'd8, 2'b11, 4'd6, 1'b0, 1'b1, 16'h0, 16'h0, 0);
        check("t4_src", src_val, 16'h00AB);
        check("t4_din", last_din, 16'h0202);
        run_op(4'd1, 2'b11, 4'd6, 1'b0, 1'b1, 16'h0, 16'h0, 2);
        check("t4_sp_src", src_val, 16'h0057);
        check("t4_sp_din", last_din, 16'h0402);
        run_op(4'd5, 2'b00, 4'd7, 1'b1, 1'b0, 16'h0, 16'h0010, 3);
        check("t5_dst_addr", dst_addr, 16'h0310);
        check("t5_dst", dst_val, 16'h5A3C);
        run_op(4'd4, 2'b10, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, -1);
        check("t6_err", {31'b0, last_err}, 1);
        run_op(4'd9, 2'b01, 4'd5, 1'b0, 1'b0, 16'h000E, 16'h0, 1);
        run_op(4'd2, 2'b01, 4'd2, 1'b1, 1'b1, 16'h0120, 16'h0400, 0);
        run_op(4'd5, 2'b00, 4'd6, 1'b0, 1'b1, 16'h0, 16'h0, 0);
        run_op(4'd3, 2'b01, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 0);
        run_op(4'd4, 2'b10, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, MEM_TIMEOUT);
        check("edge_wait_err", {31'b0, last_err}, 0);
        run_op(4'd5, 2'b00, 4'd7, 1'b1, 1'b0, 16'h0, 16'h0010, -1);

        // Reset while waiting in the source memory read: no writeback, back to idle.
        predict(4'd4, 2'b11, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0, 10);
        pred.wb   = 0;
        exp_valid = 1'b0;
        ack_wait  = 10;
        wb_seen   = 0;
        rd_seen   = 0;
        issue(4'd4, 2'b11, 4'd6, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) @(negedge clk);
        check("abort_in_mem", {31'b0, mem_rd}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_mem_rd", {31'b0, mem_rd}, 0);
        repeat (15) @(negedge clk);
        check("abort_no_wb", wb_seen, 0);
        check("abort_idle", {31'b0, busy}, 0);
        $display("op %0d: reset during source read -> busy=%0d writebacks=%0d", n_op, busy, wb_seen);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
